// File: rtl/alu_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_calc_pkg
//  Purpose  : Shared constants for the calculator front-end controller:
//             datapath widths, the 3-bit ALU operation encoding and the
//             controller state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_calc_pkg;

    localparam int WIDTH = 4;
    localparam int OPW   = 3;

    // ALU operation encoding, fixed by the downstream alu block
    localparam logic [OPW-1:0] OP_ADD = 3'b000;
    localparam logic [OPW-1:0] OP_SUB = 3'b001;
    localparam logic [OPW-1:0] OP_AND = 3'b010;
    localparam logic [OPW-1:0] OP_OR  = 3'b011;
    localparam logic [OPW-1:0] OP_XOR = 3'b100;
    localparam logic [OPW-1:0] OP_NOT = 3'b101;
    localparam logic [OPW-1:0] OP_LT  = 3'b110;
    localparam logic [OPW-1:0] OP_NOP = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_OP = 3'd2,
        GOT_B  = 3'd3,
        EXEC   = 3'd4,
        SHOW   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_calc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_calc_ctrl
//  Purpose  : Keypad-driven sequencer in front of the combinational ALU.
//             Latches operand A, operand B and the operation, runs a single
//             EXEC cycle on "equals" and captures the ALU result into an
//             accumulator used for display and for chained calculations.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             digit_valid/digit        - operand entry strobe and value
//             op_valid/op_code         - operation entry strobe and code
//             eq_valid, clr_valid      - execute / clear strobes
//             alu_a, alu_b, alu_op     - registered operands/op to the ALU
//             alu_result               - combinational ALU result
//             disp, res_valid          - display value, fresh-result pulse
//             busy, ignored            - EXEC indicator, dropped-strobe pulse
//  Revision : 1.0 - initial release
// ============================================================================
module alu_calc_ctrl
    import alu_calc_pkg::*;
#(
    parameter int WIDTH = alu_calc_pkg::WIDTH,
    parameter int OPW   = alu_calc_pkg::OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             digit_valid,
    input  logic [WIDTH-1:0] digit,
    input  logic             op_valid,
    input  logic [OPW-1:0]   op_code,
    input  logic             eq_valid,
    input  logic             clr_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] disp,
    output logic             res_valid,
    output logic             busy,
    output logic             ignored
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_disp;
    logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_acc_nxt, w_disp_nxt;
    logic [OPW-1:0]   r_op, w_op_nxt;
    logic             r_res_valid, w_res_valid_nxt;
    logic             r_ignored;
    logic             w_illegal;
    logic             w_multi;
    logic             w_any;

    // More than one strobe in a cycle: everything below the winner is dropped
    assign w_multi = (clr_valid & (eq_valid | op_valid | digit_valid))
                   | (eq_valid  & (op_valid | digit_valid))
                   | (op_valid  & digit_valid);
    assign w_any   = clr_valid | eq_valid | op_valid | digit_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_op_nxt        = r_op;
        w_acc_nxt       = r_acc;
        w_disp_nxt      = r_disp;
        w_res_valid_nxt = 1'b0;
        w_illegal       = 1'b0;

        if (r_state == EXEC) begin
            // Single execute cycle: every strobe is dropped, result captured
            w_acc_nxt       = alu_result;
            w_disp_nxt      = alu_result;
            w_res_valid_nxt = 1'b1;
            w_state_nxt     = SHOW;
            w_illegal       = w_any;
        end else if (clr_valid) begin
            w_state_nxt = IDLE;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_acc_nxt   = '0;
            w_op_nxt    = OP_NOP;
        end else begin
            case (r_state)
                IDLE, GOT_A: begin
                    if (eq_valid) begin
                        w_op_nxt    = OP_NOP;
                        w_state_nxt = EXEC;
                    end else if (op_valid) begin
                        if (r_state == IDLE) w_a_nxt = r_acc;
                        w_op_nxt    = op_code;
                        w_state_nxt = GOT_OP;
                    end else if (digit_valid) begin
                        w_a_nxt     = digit;
                        w_state_nxt = GOT_A;
                    end
                end
                GOT_OP: begin
                    if (eq_valid) begin
                        // Only unary/no-op may run without a second operand
                        if (r_op == OP_NOT || r_op == OP_NOP) begin
                            w_b_nxt     = '0;
                            w_state_nxt = EXEC;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end else if (op_valid) begin
                        w_op_nxt = op_code;
                    end else if (digit_valid) begin
                        w_b_nxt     = digit;
                        w_state_nxt = GOT_B;
                    end
                end
                GOT_B: begin
                    if (eq_valid) begin
                        w_state_nxt = EXEC;
                    end else if (op_valid) begin
                        w_illegal = 1'b1;
                    end else if (digit_valid) begin
                        w_b_nxt = digit;
                    end
                end
                SHOW: begin
                    if (eq_valid) begin
                        // Repeat: previous result becomes A, B and op kept
                        w_a_nxt     = r_acc;
                        w_state_nxt = EXEC;
                    end else if (op_valid) begin
                        w_a_nxt     = r_acc;
                        w_op_nxt    = op_code;
                        w_state_nxt = GOT_OP;
                    end else if (digit_valid) begin
                        w_a_nxt     = digit;
                        w_state_nxt = GOT_A;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // Display follows the destination state; frozen while executing
        if (r_state != EXEC) begin
            case (w_state_nxt)
                GOT_A, GOT_OP: w_disp_nxt = w_a_nxt;
                GOT_B:         w_disp_nxt = w_b_nxt;
                EXEC:          w_disp_nxt = r_disp;
                default:       w_disp_nxt = w_acc_nxt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_NOP;
            r_acc       <= '0;
            r_disp      <= '0;
            r_res_valid <= 1'b0;
            r_ignored   <= 1'b0;
        end else begin
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_op        <= w_op_nxt;
            r_acc       <= w_acc_nxt;
            r_disp      <= w_disp_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_ignored   <= w_multi | w_illegal;
        end
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign disp      = r_disp;
    assign res_valid = r_res_valid;
    assign ignored   = r_ignored;
    assign busy      = (r_state == EXEC);

endmodule
`default_nettype wire
